// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master controller and its address decoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    ERR    = 2'd3
  } state_t;

  // Only addresses whose top six bits match this prefix map onto a slave.
  localparam logic [5:0] REGION_PREFIX = 6'b100000;

  // Bit positions of the prefix and of the slave-index field in a byte address.
  localparam int PFX_HI = 31;
  localparam int PFX_LO = 26;
  localparam int IDX_HI = 25;
  localparam int IDX_LO = 24;
  localparam int IDX_W  = IDX_HI - IDX_LO + 1;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response handshake plus APB bus signals of the APB master controller.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; responses and APB are never stalled.
//   master modport: controller side (takes commands, drives APB, returns responses)
//   slave modport : requester/slave side (issues commands, returns Prdata)
interface apb_master_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [WIDTH-1:0]  cmd_addr;
  logic [WIDTH-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;
  logic [SLAVES-1:0] Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [WIDTH-1:0]  Paddr;
  logic [WIDTH-1:0]  Pwdata;
  logic [WIDTH-1:0]  Prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, Prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, Prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Maps a byte address to a one-hot slave select, or flags a decode error.
// Latency: purely combinational.
// Backpressure: none.
//   addr : byte address of the pending command
//   sel  : one-hot slave select (all zero on error)
//   err  : address is outside the slave region
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
) (
  input  logic [WIDTH-1:0]  addr,
  output logic [SLAVES-1:0] sel,
  output logic              err
);

  logic [IDX_W-1:0] idx;

  assign idx = addr[IDX_HI:IDX_LO];

  always_comb begin
    sel = '0;
    err = 1'b1;
    // An index beyond the populated slaves is treated like an unmapped address.
    if (addr[PFX_HI:PFX_LO] == REGION_PREFIX && int'(idx) < SLAVES) begin
      sel[idx] = 1'b1;
      err      = 1'b0;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// Turns valid/ready commands into zero-wait-state APB transfers and returns one response each.
// Latency: legal command accepted at edge N -> SETUP N+1, ENABLE N+2, rsp N+3; decode error -> rsp N+2.
// Backpressure: cmd_ready is low only during SETUP; responses cannot be stalled.
//   Hclk, Hreset : clock, synchronous active-high reset
//   bus          : command/response handshake and APB signals (master modport)
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
) (
  input  logic              Hclk,
  input  logic              Hreset,
  apb_master_ctrl_if.master bus
);

  state_t            state;
  logic [SLAVES-1:0] dec_sel;
  logic              dec_err;
  logic              accept;

  apb_addr_decode #(
    .WIDTH  (WIDTH),
    .SLAVES (SLAVES)
  ) u_addr_decode (
    .addr (bus.cmd_addr),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  // A new command can be taken in ENABLE, which is what makes transfers back-to-back.
  assign bus.cmd_ready = (state != SETUP);
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state         <= IDLE;
      bus.Pselx     <= '0;
      bus.Penable   <= 1'b0;
      bus.Pwrite    <= 1'b0;
      bus.Paddr     <= '0;
      bus.Pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;

      case (state)
        SETUP: begin
          state       <= ENABLE;
          bus.Penable <= 1'b1;
        end

        default: begin
          // Leaving ENABLE or ERR completes the previous command.
          if (state == ENABLE) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.Pwrite ? '0 : bus.Prdata;
          end
          if (state == ERR) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end

          bus.Penable <= 1'b0;
          if (!accept) begin
            state     <= IDLE;
            bus.Pselx <= '0;
          end else if (dec_err) begin
            // Paddr/Pwrite/Pwdata keep their last values; nothing goes on the bus.
            state     <= ERR;
            bus.Pselx <= '0;
          end else begin
            state      <= SETUP;
            bus.Pselx  <= dec_sel;
            bus.Pwrite <= bus.cmd_write;
            bus.Paddr  <= bus.cmd_addr;
            bus.Pwdata <= bus.cmd_wdata;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench: cycle-timeline model of the APB master plus directed literal scenarios.
// Latency: not applicable.
// Backpressure: commands are held until cmd_ready in directed scenarios, random otherwise.
module tb_apb_master_ctrl;
  localparam int W = 32;
  localparam int S = 4;
  localparam int R = 8;

  logic Hclk = 1'b0;
  logic Hreset;
  always #5 Hclk = ~Hclk;

  apb_master_ctrl_if #(.WIDTH(W), .SLAVES(S)) bus ();

  apb_master_ctrl #(.WIDTH(W), .SLAVES(S)) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge Hclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Prdata: random every cycle unless a directed scenario pins it.
  bit          prd_force = 1'b0;
  logic [31:0] prd_val   = '0;
  initial bus.Prdata = '0;
  always @(posedge Hclk) begin
    #1;
    bus.Prdata = prd_force ? prd_val : $urandom;
  end

  // Timeline model: what each future cycle must show, filled in when a command is accepted.
  typedef struct {
    bit          apb;
    logic [3:0]  sel;
    bit          en;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    bit          busy;
    bit          rsp;
    bit          err;
    bit          rd;
    int          prd_slot;
  } slot_t;

  slot_t       sch [R];
  logic [31:0] prd_hist [R];
  bit          model_on = 1'b0;
  logic [31:0] last_addr, last_wdata;
  bit          last_wr;

  function automatic bit legal(input logic [31:0] a);
    return (a >> 26) == 32'd32;
  endfunction

  always @(negedge Hclk) begin : model
    int s, s1, s2, s3;
    slot_t cur;
    logic [3:0]  esel;
    bit          een, ewr;
    logic [31:0] eaddr, ewdata, erdata;
    s  = cyc % R;
    s1 = (cyc + 1) % R;
    s2 = (cyc + 2) % R;
    s3 = (cyc + 3) % R;
    cur = sch[s];
    prd_hist[s] = bus.Prdata;
    if (model_on) begin
      if (cur.apb) begin
        esel = cur.sel; een = cur.en; eaddr = cur.addr; ewdata = cur.wdata; ewr = cur.wr;
      end else begin
        esel = 4'b0; een = 1'b0; eaddr = last_addr; ewdata = last_wdata; ewr = last_wr;
      end
      erdata = (cur.rsp && cur.rd) ? prd_hist[cur.prd_slot] : 32'h0;
      chk("cmd_ready", bus.cmd_ready, cur.busy ? 32'd0 : 32'd1);
      chk("Pselx",     bus.Pselx,     esel);
      chk("Penable",   bus.Penable,   een);
      chk("Paddr",     bus.Paddr,     eaddr);
      chk("Pwdata",    bus.Pwdata,    ewdata);
      chk("Pwrite",    bus.Pwrite,    ewr);
      chk("rsp_valid", bus.rsp_valid, cur.rsp);
      chk("rsp_err",   bus.rsp_err,   cur.err);
      chk("rsp_rdata", bus.rsp_rdata, erdata);
    end
    sch[s] = '{default: 0};
    if (Hreset === 1'b1) begin
      for (int k = 1; k <= 3; k++) sch[(cyc + k) % R] = '{default: 0};
      last_addr = '0; last_wdata = '0; last_wr = 1'b0;
      model_on = 1'b1;
    end else if (model_on && bus.cmd_valid === 1'b1 && !cur.busy) begin
      if (legal(bus.cmd_addr)) begin
        last_addr  = bus.cmd_addr;
        last_wdata = bus.cmd_wdata;
        last_wr    = bus.cmd_write;
        for (int k = 1; k <= 2; k++) begin
          int t;
          t = (cyc + k) % R;
          sch[t].apb   = 1'b1;
          sch[t].sel   = 4'b0001 << ((bus.cmd_addr >> 24) & 32'd3);
          sch[t].en    = (k == 2);
          sch[t].addr  = bus.cmd_addr;
          sch[t].wdata = bus.cmd_wdata;
          sch[t].wr    = bus.cmd_write;
          sch[t].busy  = (k == 1);
        end
        sch[s3].rsp      = 1'b1;
        sch[s3].err      = 1'b0;
        sch[s3].rd       = !bus.cmd_write;
        sch[s3].prd_slot = s2;
      end else begin
        sch[s2].rsp = 1'b1;
        sch[s2].err = 1'b1;
        sch[s2].rd  = 1'b0;
      end
    end
    if (s1 < 0) $display("unreachable");
  end

  // Present a command, hold it until accepted, then return early in the cycle after acceptance.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit drop);
    bit got;
    got = 1'b0;
    @(posedge Hclk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Hclk);
      got = (bus.cmd_ready === 1'b1);
    end
    chk("issue_accept", got, 1);
    @(posedge Hclk); #1;
    if (drop) bus.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    Hreset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(posedge Hclk);
    #1 Hreset = 1'b0;
    @(negedge Hclk);
    chk("rst_Pselx", bus.Pselx, 0);
    chk("rst_Paddr", bus.Paddr, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);

    // Read from slave 1 returning DEADBEEF.
    prd_force = 1'b1; prd_val = 32'hDEAD_BEEF;
    issue(1'b0, 32'h8100_0010, 32'h0, 1'b1);
    @(negedge Hclk); chk("t1_sel", bus.Pselx, 4'b0010); chk("t1_en0", bus.Penable, 0);
    @(negedge Hclk); chk("t1_en1", bus.Penable, 1);     chk("t1_norsp", bus.rsp_valid, 0);
    @(negedge Hclk); chk("t1_rsp", bus.rsp_valid, 1);   chk("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    prd_force = 1'b0;

    // Write to slave 3.
    issue(1'b1, 32'h8300_0004, 32'h1234_5678, 1'b1);
    @(negedge Hclk); chk("t2_sel", bus.Pselx, 4'b1000); chk("t2_wr", bus.Pwrite, 1);
                     chk("t2_wdata", bus.Pwdata, 32'h1234_5678);
    @(negedge Hclk); chk("t2_wdata2", bus.Pwdata, 32'h1234_5678); chk("t2_en", bus.Penable, 1);
    @(negedge Hclk); chk("t2_rsp", bus.rsp_valid, 1); chk("t2_rdata", bus.rsp_rdata, 0);

    // Two writes back-to-back with no idle cycle.
    issue(1'b1, 32'h8000_0000, 32'h1111_1111, 1'b0);
    issue(1'b1, 32'h8200_0000, 32'h2222_2222, 1'b1);
    @(negedge Hclk); chk("t3_sel2", bus.Pselx, 4'b0100); chk("t3_en0", bus.Penable, 0);
                     chk("t3_rsp1", bus.rsp_valid, 1);
    @(negedge Hclk); chk("t3_en1", bus.Penable, 1); chk("t3_gap", bus.rsp_valid, 0);
    @(negedge Hclk); chk("t3_rsp2", bus.rsp_valid, 1);

    // Unmapped read.
    issue(1'b0, 32'h4000_0000, 32'h0, 1'b1);
    @(negedge Hclk); chk("t4_sel", bus.Pselx, 0); chk("t4_en", bus.Penable, 0);
    @(negedge Hclk); chk("t4_rsp", bus.rsp_valid, 1); chk("t4_err", bus.rsp_err, 1);
                     chk("t4_rdata", bus.rsp_rdata, 0);

    // Legal read then unmapped command back-to-back.
    issue(1'b0, 32'h8000_0020, 32'h0, 1'b0);
    issue(1'b0, 32'h0000_1000, 32'h0, 1'b1);
    @(negedge Hclk); chk("t5_rsp1", bus.rsp_valid, 1); chk("t5_err1", bus.rsp_err, 0);
    @(negedge Hclk); chk("t5_rsp2", bus.rsp_valid, 1); chk("t5_err2", bus.rsp_err, 1);

    // Reset during ENABLE aborts the transfer; a command offered during reset is dropped.
    issue(1'b0, 32'h8100_0000, 32'h0, 1'b1);
    @(negedge Hclk);
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h8000_0000; bus.cmd_wdata = 32'h5;
    @(negedge Hclk); chk("t6_en", bus.Penable, 1);
    @(posedge Hclk); #1;
    Hreset = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge Hclk); chk("t6_rsp", bus.rsp_valid, 0); chk("t6_sel", bus.Pselx, 0);
                     chk("t6_en0", bus.Penable, 0); chk("t6_addr", bus.Paddr, 0);
    @(negedge Hclk); chk("t6_noacc", bus.Pselx, 0);

    // Random traffic against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge Hclk); #1;
      Hreset        = ($urandom_range(0, 99) == 0);
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.cmd_write = $urandom_range(0, 1) == 1;
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a = (32'd32 << 26) | (a & 32'h03FF_FFFF);
      else if (legal(a)) a = a & 32'h7FFF_FFFF;
      bus.cmd_addr  = a;
      bus.cmd_wdata = $urandom;
    end
    @(posedge Hclk); #1;
    Hreset = 1'b0; bus.cmd_valid = 1'b0;
    repeat (5) @(negedge Hclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
